quadrature_decoder_param: RTL and testbench

//   Parametrised quadrature decoder for incremental encoders (A/B, optional index).

---
 rtl/quadrature_decoder_param.sv | 208 ++++++++++++++++++++
 tb/tb_quadrature_decoder_param.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/quadrature_decoder_param.sv
// Quadrature decoder: synchronised, glitch-filtered A/B inputs, run-time x1/x2/x4 decode, wrapping signed count.
// Define QUAD_ENC_INDEX_EN to build the index channel (idx input, idx_seen output).
//
// state     | meaning
// ST_SETTLE | after reset release: filters follow synced inputs directly, no counts, no err
// ST_RUN    | filtered transitions decoded into counts, pulses and err
module quadrature_decoder_param #(
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    a,
    input  logic                    b,
    input  logic                    clr,
    input  logic [1:0]              mode,
    output logic signed [CNT_W-1:0] counter,
    output logic                    cw,
    output logic                    ccw,
    output logic                    dir,
    output logic                    err
`ifdef QUAD_ENC_INDEX_EN
    ,
    input  logic                    idx,
    output logic                    idx_seen
`endif
);

`ifdef QUAD_ENC_INDEX_EN
    localparam int NCH = 3;
`else
    localparam int NCH = 2;
`endif
    localparam int FW         = $clog2(FILT_LEN + 1);
    localparam int SETTLE_LEN = SYNC_STAGES + FILT_LEN;
    localparam int SW         = $clog2(SETTLE_LEN + 1);

    typedef enum logic {
        ST_SETTLE = 1'b0,
        ST_RUN    = 1'b1
    } state_t;

    state_t                          state_q, state_d;
    logic [SW-1:0]                   settle_q, settle_d;
    logic [NCH-1:0]                  raw;
    logic [NCH-1:0]                  synced;
    logic [NCH-1:0]                  filt_q;
    logic [NCH-1:0]                  prev_q;
    logic [NCH-1:0][SYNC_STAGES-1:0] sync_q;
    logic [NCH-1:0][FW-1:0]          fcnt_q;

    logic [CNT_W-1:0] counter_q, counter_d;
    logic             cw_q, cw_d;
    logic             ccw_q, ccw_d;
    logic             dir_q, dir_d;
    logic             err_q, err_d;

    logic [3:0] trans;
    logic       a_chg, b_chg, fwd, rev, gate;

`ifdef QUAD_ENC_INDEX_EN
    logic idx_seen_q, idx_seen_d;
    logic idx_rise;
    assign raw      = {idx, b, a};
    assign idx_rise = filt_q[2] & ~prev_q[2];
`else
    assign raw = {b, a};
`endif

    always_comb begin
        synced = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            synced[ch] = sync_q[ch][SYNC_STAGES-1];
        end
    end

    // Per channel: sync chain, then the filter accepts a new level only after FILT_LEN differing cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            fcnt_q <= '0;
            filt_q <= '0;
            prev_q <= '0;
        end else begin
            prev_q <= filt_q;
            for (int ch = 0; ch < NCH; ch++) begin
                sync_q[ch] <= {sync_q[ch][SYNC_STAGES-2:0], raw[ch]};
                if (state_q == ST_SETTLE) begin
                    filt_q[ch] <= synced[ch];
                    fcnt_q[ch] <= '0;
                end else if (synced[ch] != filt_q[ch]) begin
                    if (fcnt_q[ch] == FW'(FILT_LEN - 1)) begin
                        filt_q[ch] <= synced[ch];
                        fcnt_q[ch] <= '0;
                    end else begin
                        fcnt_q[ch] <= fcnt_q[ch] + FW'(1);
                    end
                end else begin
                    fcnt_q[ch] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_SETTLE;
            settle_q   <= SW'(SETTLE_LEN);
            counter_q  <= '0;
            cw_q       <= 1'b0;
            ccw_q      <= 1'b0;
            dir_q      <= 1'b0;
            err_q      <= 1'b0;
`ifdef QUAD_ENC_INDEX_EN
            idx_seen_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            settle_q   <= settle_d;
            counter_q  <= counter_d;
            cw_q       <= cw_d;
            ccw_q      <= ccw_d;
            dir_q      <= dir_d;
            err_q      <= err_d;
`ifdef QUAD_ENC_INDEX_EN
            idx_seen_q <= idx_seen_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        settle_d  = settle_q;
        counter_d = counter_q;
        cw_d      = 1'b0;
        ccw_d     = 1'b0;
        dir_d     = dir_q;
        err_d     = err_q;
`ifdef QUAD_ENC_INDEX_EN
        idx_seen_d = idx_seen_q;
`endif
        trans = {prev_q[0], prev_q[1], filt_q[0], filt_q[1]};
        a_chg = prev_q[0] ^ filt_q[0];
        b_chg = prev_q[1] ^ filt_q[1];
        fwd   = 1'b0;
        rev   = 1'b0;

        // {prev a, prev b, new a, new b}; CW order is 00 -> 10 -> 11 -> 01 -> 00
        case (trans)
            4'b0010, 4'b1011, 4'b1101, 4'b0100: fwd = 1'b1;
            4'b0001, 4'b0111, 4'b1110, 4'b1000: rev = 1'b1;
            default: ;
        endcase

        case (mode)
            2'b00:   gate = a_chg & ~filt_q[1];
            2'b01:   gate = a_chg;
            default: gate = 1'b1;
        endcase

        if (state_q == ST_SETTLE) begin
            settle_d = settle_q - SW'(1);
            if (settle_q == SW'(1)) begin
                state_d = ST_RUN;
            end
        end else begin
            if (a_chg && b_chg) begin
                err_d = 1'b1;
            end else if (fwd && gate) begin
                counter_d = counter_q + CNT_W'(1);
                cw_d      = 1'b1;
                dir_d     = 1'b1;
            end else if (rev && gate) begin
                counter_d = counter_q - CNT_W'(1);
                ccw_d     = 1'b1;
                dir_d     = 1'b0;
            end
`ifdef QUAD_ENC_INDEX_EN
            if (idx_rise) begin
                counter_d  = '0;
                idx_seen_d = 1'b1;
            end
`endif
        end

        if (clr) begin
            counter_d = '0;
            err_d     = 1'b0;
            cw_d      = 1'b0;
            ccw_d     = 1'b0;
            dir_d     = dir_q;
`ifdef QUAD_ENC_INDEX_EN
            idx_seen_d = 1'b0;
`endif
        end
    end

    assign counter = counter_q;
    assign cw      = cw_q;
    assign ccw     = ccw_q;
    assign dir     = dir_q;
    assign err     = err_q;
`ifdef QUAD_ENC_INDEX_EN
    assign idx_seen = idx_seen_q;
`endif

endmodule

// File: tb/tb_quadrature_decoder_param.sv
// Directed bench for quadrature_decoder_param: default instance plus an 8-bit-counter instance.
module tb_quadrature_decoder_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset, a, b, clr;
    logic [1:0]         mode;
    logic signed [31:0] counter;
    logic               cw, ccw, dir, err;

    logic               a8, b8, clr8;
    logic [1:0]         mode8;
    logic signed [7:0]  counter8;
    logic               cw8, ccw8, dir8, err8;

`ifdef QUAD_ENC_INDEX_EN
    logic idx, idx_seen, idx8, idx_seen8;
`endif

    quadrature_decoder_param dut (
        .clk(clk), .reset(reset), .a(a), .b(b), .clr(clr), .mode(mode),
        .counter(counter), .cw(cw), .ccw(ccw), .dir(dir), .err(err)
`ifdef QUAD_ENC_INDEX_EN
        , .idx(idx), .idx_seen(idx_seen)
`endif
    );

    quadrature_decoder_param #(.CNT_W(8)) dut8 (
        .clk(clk), .reset(reset), .a(a8), .b(b8), .clr(clr8), .mode(mode8),
        .counter(counter8), .cw(cw8), .ccw(ccw8), .dir(dir8), .err(err8)
`ifdef QUAD_ENC_INDEX_EN
        , .idx(idx8), .idx_seen(idx_seen8)
`endif
    );

    int passes = 0;
    int checks = 0;
    int cw_hi = 0, cw_rise = 0, ccw_rise = 0, cw8_rise = 0, ccw8_rise = 0, both_seen = 0;
    logic cw_prev = 1'b0, ccw_prev = 1'b0, cw8_prev = 1'b0, ccw8_prev = 1'b0;
    int p, p8;
    logic [1:0] seq [4];

    always @(negedge clk) begin
        if (cw) cw_hi++;
        if (cw && !cw_prev) cw_rise++;
        if (ccw && !ccw_prev) ccw_rise++;
        if (cw8 && !cw8_prev) cw8_rise++;
        if (ccw8 && !ccw8_prev) ccw8_rise++;
        if ((cw && ccw) || (cw8 && ccw8)) both_seen++;
        cw_prev  = cw;
        ccw_prev = ccw;
        cw8_prev = cw8;
        ccw8_prev = ccw8;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0d (0x%0h) expected=%0d (0x%0h)", tag, obs, obs, exp, exp);
    endtask

    // One quadrature step per call iteration, 50 clocks each; caller sits 1 time unit after a rising edge.
    task automatic qstep(input bit sel8, input bit fwd, input int n);
        for (int i = 0; i < n; i++) begin
            if (sel8) begin
                p8 = fwd ? (p8 + 1) % 4 : (p8 + 3) % 4;
                {a8, b8} = seq[p8];
            end else begin
                p = fwd ? (p + 1) % 4 : (p + 3) % 4;
                {a, b} = seq[p];
            end
            repeat (50) @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_clr(input bit sel8);
        if (sel8) clr8 = 1'b1; else clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        clr8 = 1'b0;
    endtask

    initial begin
        int lat;
        int r0;
        seq[0] = 2'b00; seq[1] = 2'b10; seq[2] = 2'b11; seq[3] = 2'b01;
        reset = 1'b1; a = 1'b0; b = 1'b0; clr = 1'b0; mode = 2'b10;
        a8 = 1'b0; b8 = 1'b0; clr8 = 1'b0; mode8 = 2'b10;
`ifdef QUAD_ENC_INDEX_EN
        idx = 1'b0; idx8 = 1'b0;
`endif
        p = 0; p8 = 0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_counter", counter, 0);
        chk("reset_pulses", {cw, ccw}, 0);
        chk("reset_dir_err", {dir, err}, 0);
        reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;

        // 1: first CW step latency, then 3 more CW steps in x4
        p = 1;
        {a, b} = seq[p];
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (cw) begin
                lat = k;
                break;
            end
        end
        chk("cw_latency", lat, 7);
        repeat (50) @(posedge clk);
        #1;
        qstep(0, 1, 3);
        chk("x4_cw_counter", counter, 4);
        chk("x4_cw_pulses", cw_rise, 4);
        chk("x4_cw_single_cycle", cw_hi, 4);
        chk("x4_cw_dir", dir, 1);

        // 2: 8 CCW steps in x4
        r0 = ccw_rise;
        qstep(0, 0, 8);
        chk("x4_ccw_counter", counter, -4);
        chk("x4_ccw_pulses", ccw_rise - r0, 8);
        chk("x4_ccw_dir", dir, 0);
        chk("x4_ccw_err", err, 0);

        // 3: resolution modes
        pulse_clr(0);
        chk("clr_counter", counter, 0);
        mode = 2'b00;
        qstep(0, 1, 8);
        chk("x1_cw", counter, 2);
        mode = 2'b01;
        qstep(0, 1, 8);
        chk("x2_cw", counter, 6);
        mode = 2'b10;
        qstep(0, 1, 8);
        chk("x4_cw8", counter, 14);
        mode = 2'b00;
        qstep(0, 0, 8);
        chk("x1_ccw", counter, 12);
        mode = 2'b11;
        qstep(0, 0, 4);
        chk("mode11_ccw", counter, 8);

        // 4: glitch rejection, illegal transition, clear
        r0 = cw_rise;
        a = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        a = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        chk("glitch_counter", counter, 8);
        chk("glitch_pulses", cw_rise - r0, 0);
        chk("glitch_err", err, 0);
        a = 1'b1; b = 1'b1; p = 2;
        repeat (50) @(posedge clk);
        #1;
        chk("illegal_err", err, 1);
        chk("illegal_counter", counter, 8);
        chk("illegal_dir", dir, 0);
        pulse_clr(0);
        chk("clr_after_err_counter", counter, 0);
        chk("clr_after_err_err", err, 0);

        // 5: 8-bit wrap and clr coincident with a count
        r0 = ccw8_rise;
        qstep(1, 0, 1);
        chk("w8_ccw_wrap", {24'd0, counter8}, 32'hFF);
        chk("w8_ccw_pulse", ccw8_rise - r0, 1);
        pulse_clr(1);
        qstep(1, 1, 128);
        chk("w8_cw128", {24'd0, counter8}, 32'h80);
        chk("w8_dir", dir8, 1);
        r0 = cw8_rise;
        p8 = (p8 + 1) % 4;
        {a8, b8} = seq[p8];
        repeat (6) @(posedge clk);
        #1;
        clr8 = 1'b1;
        @(posedge clk);
        #1;
        clr8 = 1'b0;
        chk("w8_clr_coincident", {24'd0, counter8}, 0);
        repeat (50) @(posedge clk);
        #1;
        chk("w8_clr_no_pulse", cw8_rise - r0, 0);
        chk("w8_clr_counter_hold", {24'd0, counter8}, 0);
        chk("w8_err", err8, 0);

        // 6: index behaviour
        mode = 2'b10;
        qstep(0, 1, 37);
        chk("pre_idx_counter", counter, 37);
`ifdef QUAD_ENC_INDEX_EN
        chk("idx_seen_before", idx_seen, 0);
        idx = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("idx_not_yet", counter, 37);
        @(posedge clk);
        #1;
        chk("idx_counter_zero", counter, 0);
        chk("idx_seen_set", idx_seen, 1);
        repeat (3) @(posedge clk);
        #1;
        idx = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        pulse_clr(0);
        chk("idx_seen_cleared", idx_seen, 0);
`else
        repeat (60) @(posedge clk);
        #1;
        chk("no_idx_counter_hold", counter, 37);
`endif

        chk("never_both_pulses", both_seen, 0);

        // asynchronous reset mid-operation
        reset = 1'b1;
        #2;
        chk("midreset_counter", counter, 0);
        chk("midreset_dir_err", {dir, err}, 0);
        chk("midreset_counter8", {24'd0, counter8}, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
